// File: rtl/spike_serializer_pkg.sv
// spike_serializer_pkg: shared widths, flit count and serializer FSM encoding.
package spike_serializer_pkg;
  localparam int PACKET_WIDTH     = 32;
  localparam int FLIT_WIDTH       = 4;
  localparam int FLITS_PER_PACKET = PACKET_WIDTH / FLIT_WIDTH;
  localparam int FIFO_DEPTH       = 4;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: single-clock packet buffer; full/empty come from registered occupancy only.
module spike_fifo import spike_serializer_pkg::*; #(
  parameter int WIDTH = PACKET_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     neu_clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  always_ff @(posedge neu_clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge neu_clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;
endmodule

// File: rtl/spike_serializer.sv
// spike_serializer: buffers spike packets and streams them MSB-first as flits to a router port.
module spike_serializer import spike_serializer_pkg::*; #(
  parameter int PACKET_WIDTH = spike_serializer_pkg::PACKET_WIDTH,
  parameter int FLIT_WIDTH   = spike_serializer_pkg::FLIT_WIDTH,
  parameter int FIFO_DEPTH   = spike_serializer_pkg::FIFO_DEPTH
) (
  input  logic                    neu_clk,
  input  logic                    rst_n,
  input  logic [PACKET_WIDTH-1:0] pkt_in,
  input  logic                    pkt_wr,
  output logic                    pkt_full,
  output logic [FLIT_WIDTH-1:0]   flit_out,
  output logic                    flit_valid,
  input  logic                    flit_ready,
  output logic                    flit_head,
  output logic                    flit_tail,
  output logic [7:0]              pkt_sent,
  output logic                    overflow
);
  localparam int FLITS = PACKET_WIDTH / FLIT_WIDTH;
  localparam int IW    = FLITS > 1 ? $clog2(FLITS) : 1;
  state_t                      r_state, w_next;
  logic [PACKET_WIDTH-1:0]     r_shift, w_head_pkt;
  logic [IW-1:0]               r_idx;
  logic [7:0]                  r_sent;
  logic                        r_ovf;
  logic                        w_full, w_empty, w_xfer, w_last, w_pop;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  spike_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .neu_clk (neu_clk),
    .rst_n   (rst_n),
    .i_push  (pkt_wr),
    .i_pop   (w_pop),
    .i_data  (pkt_in),
    .o_data  (w_head_pkt),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  assign w_last   = r_idx == IW'(FLITS - 1);
  assign w_xfer   = flit_valid & flit_ready;
  // Popping on the tail transfer is what lets the next head follow with no bubble.
  assign w_pop    = ~w_empty & ((r_state == IDLE) | (w_xfer & w_last));
  assign pkt_full = w_full;
  assign pkt_sent = r_sent;
  assign overflow = r_ovf;
  always_ff @(posedge neu_clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_empty ? IDLE : SEND)
                             : ((w_xfer & w_last & (w_count == '0)) ? IDLE : SEND);
  always_comb begin
    flit_valid = r_state == SEND;
    flit_out   = flit_valid ? r_shift[PACKET_WIDTH-1 -: FLIT_WIDTH] : '0;
    flit_head  = flit_valid & (r_idx == '0);
    flit_tail  = flit_valid & w_last;
  end
  always_ff @(posedge neu_clk or negedge rst_n)
    if (!rst_n) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_sent  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_shift <= w_head_pkt;
        r_idx   <= '0;
      end else if (w_xfer) begin
        r_shift <= r_shift << FLIT_WIDTH;
        r_idx   <= r_idx + 1'b1;
      end
      if (w_xfer & w_last) r_sent <= r_sent + 8'd1;
      if (pkt_wr & w_full) r_ovf <= 1'b1;
    end
endmodule

// File: tb/tb_spike_serializer.sv
// tb_spike_serializer: directed + random stimulus, queue-based reference model and flit scoreboard.
module tb_spike_serializer;
  localparam int PW = 32, FW = 4, NF = PW / FW, DEPTH = 4;
  logic          neu_clk = 1'b0, rst_n = 1'b1;
  logic [PW-1:0] pkt_in = '0;
  logic          pkt_wr = 1'b0, flit_ready = 1'b0;
  logic          pkt_full, flit_valid, flit_head, flit_tail, overflow;
  logic [FW-1:0] flit_out;
  logic [7:0]    pkt_sent;
  typedef struct packed {logic [FW-1:0] f; logic h; logic t;} flit_t;
  flit_t         exp_q[$];
  int            m_cnt = 0, m_left = 0, n_tests = 0, n_fail = 0;
  logic [7:0]    m_sent = '0;
  logic          m_ovf = 1'b0;

  always #5 neu_clk = ~neu_clk;

  spike_serializer dut (
    .neu_clk(neu_clk), .rst_n(rst_n), .pkt_in(pkt_in), .pkt_wr(pkt_wr),
    .pkt_full(pkt_full), .flit_out(flit_out), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .flit_head(flit_head), .flit_tail(flit_tail),
    .pkt_sent(pkt_sent), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: m_cnt packets waiting, m_left flits still owed for the packet on the wire.
  always @(posedge neu_clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_left = 0; m_sent = '0; m_ovf = 1'b0;
    end else begin
      int  sz;
      bit  acc;
      sz  = m_cnt;
      acc = pkt_wr && sz < DEPTH;
      if (pkt_wr && !acc) m_ovf = 1'b1;
      if (m_left > 0 && flit_ready) begin
        m_left--;
        if (m_left == 0) m_sent++;
      end
      if (m_left == 0 && sz > 0) begin
        m_cnt--;
        m_left = NF;
      end
      if (acc) begin
        m_cnt++;
        for (int i = 0; i < NF; i++)
          exp_q.push_back('{f: FW'(pkt_in >> (PW - FW * (i + 1))), h: i == 0, t: i == NF - 1});
      end
    end
  end

  always @(negedge neu_clk) if (rst_n) begin
    chk("valid", 32'(flit_valid), 32'(m_left > 0));
    chk("full", 32'(pkt_full), 32'(m_cnt == DEPTH));
    chk("sent", 32'(pkt_sent), 32'(m_sent));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (flit_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL flit: got unexpected flit %0h, expected none at %0t", flit_out, $time);
      end else begin
        chk("flit", 32'(flit_out), 32'(exp_q[0].f));
        chk("head", 32'(flit_head), 32'(exp_q[0].h));
        chk("tail", 32'(flit_tail), 32'(exp_q[0].t));
        if (flit_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge neu_clk); #1; end
  endtask
  task automatic wr(input logic [PW-1:0] d);
    pkt_wr = 1'b1; pkt_in = d; tick(); pkt_wr = 1'b0;
  endtask
  task automatic wait_left(input int v);
    for (int k = 0; k < 50 && m_left != v; k++) tick();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(flit_valid), 0);
    chk({tag, "_flit"}, 32'(flit_out), 0);
    chk({tag, "_head"}, 32'(flit_head), 0);
    chk({tag, "_tail"}, 32'(flit_tail), 0);
    chk({tag, "_full"}, 32'(pkt_full), 0);
    chk({tag, "_sent"}, 32'(pkt_sent), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask
  task automatic reset_pulse();
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("rst");
    tick(2);
    rst_n = 1'b1;
    // single packet, full throughput
    flit_ready = 1'b1;
    wr(32'h12345678);
    chk("lat_idle", 32'(flit_valid), 0);
    for (int i = 0; i < NF; i++) begin
      tick();
      chk("seq_flit", 32'(flit_out), 32'(i + 1));
      chk("seq_head", 32'(flit_head), 32'(i == 0));
      chk("seq_tail", 32'(flit_tail), 32'(i == NF - 1));
    end
    tick();
    chk("seq_done", 32'(flit_valid), 0);
    chk("seq_sent", 32'(pkt_sent), 1);
    // backpressure on flit index 2
    wr(32'h12345678);
    wait_left(NF - 2);
    flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_flit", 32'(flit_out), 3);
      chk("stall_valid", 32'(flit_valid), 1);
    end
    flit_ready = 1'b1;
    tick(10);
    // occupy the shift register, then overfill the buffer
    flit_ready = 1'b0;
    wr($urandom);
    tick();
    for (int i = 0; i < 5; i++) begin
      wr($urandom);
      if (i == 3) begin
        chk("fill_full", 32'(pkt_full), 1);
        chk("fill_ovf", 32'(overflow), 0);
      end
    end
    chk("drop_ovf", 32'(overflow), 1);
    flit_ready = 1'b1;
    tick(60);
    chk("burst_sent", 32'(pkt_sent), 7);
    // writes coinciding with a tail transfer
    reset_pulse();
    flit_ready = 1'b0;
    wr($urandom);
    tick();
    repeat (4) wr($urandom);
    flit_ready = 1'b1;
    wait_left(1);
    chk("tail_full", 32'(flit_tail), 1);
    wr($urandom);
    chk("tail_drop_ovf", 32'(overflow), 1);
    chk("tail_drop_cnt", 32'(dut.w_count), 3);
    wait_left(1);
    chk("tail3", 32'(flit_tail), 1);
    wr($urandom);
    chk("tail_acc_cnt", 32'(dut.w_count), 3);
    chk("tail_acc_full", 32'(pkt_full), 0);
    tick(50);
    // reset mid-packet
    reset_pulse();
    wr(32'hDEADBEEF);
    wait_left(NF - 4);
    chk("mid_flit", 32'(flit_out), 32'hB);
    rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    tick(2);
    rst_n = 1'b1;
    wr(32'hA5A5A5A5);
    tick();
    chk("post_head_flit", 32'(flit_out), 32'hA);
    chk("post_head", 32'(flit_head), 1);
    tick(12);
    // random traffic, long enough to wrap pkt_sent
    for (int c = 0; c < 5000; c++) begin
      pkt_wr     = $urandom_range(0, 99) < 20;
      pkt_in     = $urandom;
      flit_ready = $urandom_range(0, 99) < (((c / 500) % 2) ? 40 : 85);
      tick();
    end
    pkt_wr = 1'b0;
    flit_ready = 1'b1;
    tick(60);
    chk("drain_q", 32'(exp_q.size()), 0);
    chk("drain_valid", 32'(flit_valid), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
